// File: rtl/seg7_pkg.sv
// Shared encodings for the 7-segment frame sequencer: mode codes, segment byte type
// and the frame/direction FSM states.
package seg7_pkg;

    typedef logic [7:0] seg_byte_t;

    localparam logic [1:0] MODE_HOLD     = 2'd0;
    localparam logic [1:0] MODE_LOOP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;
    localparam logic [1:0] MODE_ONESHOT  = 2'd3;

    localparam seg_byte_t SEG_BLANK = 8'hFF;

    // Direction and the one-shot completion share one state register.
    typedef enum logic [1:0] {
        ST_UP   = 2'd0,
        ST_DOWN = 2'd1,
        ST_DONE = 2'd2
    } frame_state_e;

endpackage

// File: rtl/seg7_scan_timer.sv
// Refresh, dwell and blink timing for the sequencer. All counters freeze while
// enable_i is low; restart_i returns them to zero with the blink phase on.
module seg7_scan_timer #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_CYCLES = 100000,
    parameter int DWELL_SCANS    = 200,
    parameter int BLINK_SCANS    = 50,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          enable_i,
    input  logic          restart_i,
    output logic [DW-1:0] digit_idx_o,
    output logic          scan_tick_o,
    output logic          dwell_tick_o,
    output logic          blink_on_o
);

    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
    localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [DW-1:0] DIGIT_LAST   = DW'(DIGITS - 1);
    localparam logic [SW-1:0] DWELL_LAST   = SW'(DWELL_SCANS - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_SCANS - 1);

    logic [RW-1:0] refresh_q, refresh_d;
    logic [DW-1:0] digit_q, digit_d;
    logic [SW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic          refresh_wrap;

    always_comb begin
        refresh_wrap = enable_i && (refresh_q == REFRESH_LAST);
        scan_tick_o  = refresh_wrap && (digit_q == DIGIT_LAST);
        dwell_tick_o = scan_tick_o && (dwell_q == DWELL_LAST);
        refresh_d    = refresh_q;
        digit_d      = digit_q;
        dwell_d      = dwell_q;
        blink_cnt_d  = blink_cnt_q;
        blink_on_d   = blink_on_q;
        if (restart_i) begin
            refresh_d   = '0;
            digit_d     = '0;
            dwell_d     = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (enable_i) begin
            refresh_d = refresh_wrap ? '0 : refresh_q + 1'b1;
            if (refresh_wrap) begin
                digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
            end
            if (scan_tick_o) begin
                dwell_d     = (dwell_q == DWELL_LAST) ? '0 : dwell_q + 1'b1;
                blink_cnt_d = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_on_d = ~blink_on_q;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            refresh_q   <= '0;
            digit_q     <= '0;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            refresh_q   <= refresh_d;
            digit_q     <= digit_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
        end
    end

    assign digit_idx_o = digit_q;
    assign blink_on_o  = blink_on_q;

endmodule

// File: rtl/seg7_frame_sequencer.sv
// Multiplexed 7-segment display sequencer: frame buffer, frame/direction FSM and
// registered anode/segment drivers, timed by seg7_scan_timer.
module seg7_frame_sequencer
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int FRAMES         = 8,
    parameter int REFRESH_CYCLES = 100000,
    parameter int DWELL_SCANS    = 200,
    parameter int BLINK_SCANS    = 50,
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic              restart,
    input  logic              blink,
    input  logic              wr_en,
    input  logic [FW-1:0]     wr_frame,
    input  logic [DW-1:0]     wr_digit,
    input  seg_byte_t         wr_data,
    output logic [DIGITS-1:0] an,
    output seg_byte_t         seg,
    output logic [FW-1:0]     frame_idx,
    output logic              done
);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

    logic [DW-1:0] digit_idx;
    logic          scan_tick, dwell_tick, blink_on, advance, wr_hit;

    seg_byte_t     fb_q [FRAMES][DIGITS];
    frame_state_e  state_q, state_d;
    logic [FW-1:0] frame_q, frame_d;
    logic [1:0]    mode_q;
    logic [DIGITS-1:0] an_q, an_d;
    seg_byte_t     seg_q, seg_d;

    seg7_scan_timer #(
        .DIGITS        (DIGITS),
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .DWELL_SCANS   (DWELL_SCANS),
        .BLINK_SCANS   (BLINK_SCANS)
    ) u_timer (
        .clock       (clock),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .restart_i   (restart),
        .digit_idx_o (digit_idx),
        .scan_tick_o (scan_tick),
        .dwell_tick_o(dwell_tick),
        .blink_on_o  (blink_on)
    );

    assign advance = scan_tick && dwell_tick;
    assign wr_hit  = wr_en && (int'(wr_frame) < FRAMES) && (int'(wr_digit) < DIGITS);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < FRAMES; f++) begin
                for (int d = 0; d < DIGITS; d++) begin
                    fb_q[f][d] <= SEG_BLANK;
                end
            end
        end else if (wr_hit) begin
            fb_q[wr_frame][wr_digit] <= wr_data;
        end
    end

    // Mode edits only retarget the next advance; they never move the frame themselves.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        if (mode != mode_q) begin
            if (mode == MODE_PINGPONG || state_q == ST_DONE) begin
                state_d = ST_UP;
            end
        end
        if (restart) begin
            state_d = ST_UP;
            frame_d = '0;
        end else if (advance) begin
            case (mode)
                MODE_LOOP: begin
                    frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
                end
                MODE_PINGPONG: begin
                    if (FRAMES > 1) begin
                        if (state_d == ST_DOWN) begin
                            if (frame_q == '0) begin
                                frame_d = frame_q + 1'b1;
                                state_d = ST_UP;
                            end else begin
                                frame_d = frame_q - 1'b1;
                            end
                        end else if (frame_q == FRAME_LAST) begin
                            frame_d = frame_q - 1'b1;
                            state_d = ST_DOWN;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q != ST_DONE) begin
                        if (frame_q == FRAME_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            frame_d = frame_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A write landing on the lit digit is forwarded so it shows one cycle later.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (enable && (blink_on || !blink)) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (i == DIGITS - 1 - int'(digit_idx)) begin
                    an_d[i] = 1'b0;
                end
            end
            seg_d = (wr_hit && wr_frame == frame_q && wr_digit == digit_idx)
                    ? wr_data : fb_q[frame_q][digit_idx];
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_UP;
            frame_q <= '0;
            mode_q  <= MODE_HOLD;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            mode_q  <= mode;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign frame_idx = frame_q;
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_seg7_frame_sequencer.sv
// Bench for seg7_frame_sequencer: a 4x4 instance driven from a vector table plus
// hand sequences, and a 5-digit single-frame instance for range and FRAMES=1 cases.
module tb_seg7_frame_sequencer;
    import seg7_pkg::*;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       enable, restart, blink, wr_en;
    logic [1:0] mode, wr_frame, wr_digit;
    logic [7:0] wr_data, seg;
    logic [3:0] an;
    logic [1:0] frame_idx;
    logic       done;

    logic       s_enable, s_restart, s_blink, s_wr_en;
    logic [1:0] s_mode;
    logic [0:0] s_wr_frame, s_frame_idx;
    logic [2:0] s_wr_digit;
    logic [7:0] s_wr_data, s_seg;
    logic [4:0] s_an;
    logic       s_done;

    int         n_vec = 0;
    int         n_err = 0;
    int         cur_t;
    logic [20:0] exp_q[$];
    logic [7:0]  s_pat [5];

    typedef struct {
        logic [1:0]  mode;
        logic        blink;
        int          t;
        logic [20:0] exp;
    } vec_t;
    typedef struct {
        logic [1:0] mode;
        logic       blink;
        int         len;
    } run_t;
    vec_t vecs[$];
    run_t runs[5];

    always #5 clock = ~clock;

    seg7_frame_sequencer #(
        .DIGITS(4), .FRAMES(4), .REFRESH_CYCLES(4), .DWELL_SCANS(2), .BLINK_SCANS(3)
    ) dut (
        .clock(clock), .rst_n(rst_n), .enable(enable), .mode(mode), .restart(restart),
        .blink(blink), .wr_en(wr_en), .wr_frame(wr_frame), .wr_digit(wr_digit),
        .wr_data(wr_data), .an(an), .seg(seg), .frame_idx(frame_idx), .done(done)
    );

    seg7_frame_sequencer #(
        .DIGITS(5), .FRAMES(1), .REFRESH_CYCLES(4), .DWELL_SCANS(2), .BLINK_SCANS(3)
    ) dut_small (
        .clock(clock), .rst_n(rst_n), .enable(s_enable), .mode(s_mode), .restart(s_restart),
        .blink(s_blink), .wr_en(s_wr_en), .wr_frame(s_wr_frame), .wr_digit(s_wr_digit),
        .wr_data(s_wr_data), .an(s_an), .seg(s_seg), .frame_idx(s_frame_idx), .done(s_done)
    );

    function automatic logic [20:0] pack_out(input logic [7:0] a, input logic [7:0] s,
                                             input logic [3:0] f, input logic dn);
        return {a, s, f, dn};
    endfunction

    function automatic logic [20:0] main_out();
        return pack_out({4'h0, an}, seg, {2'b00, frame_idx}, done);
    endfunction

    function automatic logic [20:0] small_out();
        return pack_out({3'b000, s_an}, s_seg, {3'b000, s_frame_idx}, s_done);
    endfunction

    function automatic logic [7:0] pat(input int f, input int d);
        if (f == 0) begin
            case (d)
                0: return 8'hC1;
                1: return 8'hA3;
                2: return 8'h87;
                default: return 8'h8B;
            endcase
        end
        return 8'(16 * f + d);
    endfunction

    // Frame reached after n advance events, straight from the mode definitions.
    function automatic int frame_of(input logic [1:0] md, input int n);
        int r;
        case (md)
            MODE_LOOP: return n % 4;
            MODE_PINGPONG: begin
                r = n % 6;
                return (r <= 3) ? r : 6 - r;
            end
            MODE_ONESHOT: return (n > 3) ? 3 : n;
            default: return 0;
        endcase
    endfunction

    // t counts clock edges since the restart edge (t=1); digits are lit 4 edges each,
    // a frame lasts 32 edges, outputs trail the timer state by one edge.
    function automatic logic [20:0] exp_main(input logic [1:0] md, input logic bl, input int t);
        int d, ns, nf;
        logic [3:0] a;
        logic [7:0] s;
        d  = ((t - 2) / 4) % 4;
        ns = (t - 2) / 32;
        nf = (t - 1) / 32;
        a  = ~(4'b1000 >> d);
        s  = pat(frame_of(md, ns), d);
        if (bl && ((((t - 2) / 16) / 3) % 2 == 1)) begin
            a = 4'hF;
            s = 8'hFF;
        end
        return pack_out({4'h0, a}, s, 4'(frame_of(md, nf)), (md == MODE_ONESHOT) && (nf >= 4));
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic advance_to(input int target);
        while (cur_t < target) begin
            tick();
            cur_t++;
        end
    endtask

    task automatic sb_check(input string name, input logic [20:0] got);
        logic [20:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: scoreboard empty, got %h", name, got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: got {an,seg,frame,done}=%h expected %h", name, got, e);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic write_byte(input logic [1:0] f, input logic [1:0] d, input logic [7:0] v);
        wr_en    = 1'b1;
        wr_frame = f;
        wr_digit = d;
        wr_data  = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic restart_run(input logic [1:0] md, input logic bl);
        mode    = md;
        blink   = bl;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cur_t   = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        enable = 1'b0; restart = 1'b0; blink = 1'b0; wr_en = 1'b0;
        mode = MODE_HOLD; wr_frame = '0; wr_digit = '0; wr_data = '0;
        s_enable = 1'b0; s_restart = 1'b0; s_blink = 1'b0; s_wr_en = 1'b0;
        s_mode = MODE_HOLD; s_wr_frame = '0; s_wr_digit = '0; s_wr_data = '0;
        s_pat = '{8'h91, 8'h92, 8'h94, 8'h98, 8'hB0};
        runs[0] = '{MODE_HOLD,     1'b0, 110};
        runs[1] = '{MODE_LOOP,     1'b0, 170};
        runs[2] = '{MODE_PINGPONG, 1'b0, 260};
        runs[3] = '{MODE_ONESHOT,  1'b0, 200};
        runs[4] = '{MODE_LOOP,     1'b1, 200};
        foreach (runs[r]) begin
            for (int t = 2; t <= runs[r].len; t++) begin
                vecs.push_back('{runs[r].mode, runs[r].blink, t, exp_main(runs[r].mode, runs[r].blink, t)});
            end
        end

        // Reset state
        #12;
        exp_q.push_back(pack_out(8'h0F, 8'hFF, 4'h0, 1'b0));
        sb_check("reset_main", main_out());
        exp_q.push_back(pack_out(8'h1F, 8'hFF, 4'h0, 1'b0));
        sb_check("reset_small", small_out());
        tick();
        rst_n = 1'b1;

        // Single-frame, five-digit instance: out-of-range writes and ping-pong on one frame
        for (int d = 0; d < 5; d++) begin
            s_wr_en = 1'b1; s_wr_frame = 1'b0; s_wr_digit = 3'(d); s_wr_data = s_pat[d];
            tick();
        end
        s_wr_digit = 3'd5; s_wr_data = 8'h00; tick();
        s_wr_frame = 1'b1; s_wr_digit = 3'd0; tick();
        s_wr_en = 1'b0;
        s_mode = MODE_PINGPONG; s_enable = 1'b1; s_restart = 1'b1;
        tick();
        s_restart = 1'b0;
        for (int t = 2; t <= 130; t++) begin
            exp_q.push_back(pack_out({3'b000, ~(5'b10000 >> ((t - 2) / 4 % 5))},
                                     s_pat[(t - 2) / 4 % 5], 4'h0, 1'b0));
            tick();
            sb_check($sformatf("small_t%0d", t), small_out());
        end
        s_enable = 1'b0;

        // Load every frame of the main instance while it is idle
        for (int f = 0; f < 4; f++) begin
            for (int d = 0; d < 4; d++) begin
                write_byte(2'(f), 2'(d), pat(f, d));
            end
        end
        enable = 1'b1;

        // Table of timed vectors; a new mode/blink entry starts with a restart pulse
        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].mode != vecs[i-1].mode || vecs[i].blink != vecs[i-1].blink) begin
                restart_run(vecs[i].mode, vecs[i].blink);
            end
            exp_q.push_back(vecs[i].exp);
            advance_to(vecs[i].t);
            sb_check($sformatf("vec_m%0d_b%0d_t%0d", vecs[i].mode, vecs[i].blink, vecs[i].t), main_out());
        end

        // Restart wins over an advance on the same edge
        restart_run(MODE_LOOP, 1'b0);
        advance_to(32);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cur_t = 1;
        chk("restart_vs_advance", frame_idx, 0);
        advance_to(33);
        chk("after_restart_advance", frame_idx, 1);

        // One-shot completion, restart, then a mode change clears done
        restart_run(MODE_ONESHOT, 1'b0);
        advance_to(140);
        chk("oneshot_done", {frame_idx, done}, {2'd3, 1'b1});
        restart = 1'b1;
        tick();
        restart = 1'b0;
        cur_t = 1;
        chk("oneshot_restart", {frame_idx, done}, {2'd0, 1'b0});
        advance_to(140);
        mode = MODE_LOOP;
        tick();
        cur_t++;
        chk("mode_change_clears_done", {frame_idx, done}, {2'd3, 1'b0});
        advance_to(161);
        chk("new_mode_at_advance", frame_idx, 0);

        // Re-entering ping-pong while heading down restarts the climb
        restart_run(MODE_PINGPONG, 1'b0);
        advance_to(130);
        chk("pp_descending", frame_idx, 2);
        mode = MODE_LOOP;
        tick();
        cur_t++;
        mode = MODE_PINGPONG;
        advance_to(161);
        chk("pp_reentry_up", frame_idx, 3);

        // Freeze just before an advance, then resume from the held count
        restart_run(MODE_LOOP, 1'b0);
        advance_to(30);
        enable = 1'b0;
        exp_q.push_back(pack_out(8'h0F, 8'hFF, 4'h0, 1'b0));
        tick();
        sb_check("disable_blank", main_out());
        repeat (19) tick();
        exp_q.push_back(pack_out(8'h0F, 8'hFF, 4'h0, 1'b0));
        sb_check("disable_frozen", main_out());
        enable = 1'b1;
        for (int k = 31; k <= 42; k++) begin
            exp_q.push_back(exp_main(MODE_LOOP, 1'b0, k));
            tick();
            sb_check($sformatf("resume_t%0d", k), main_out());
        end

        // Write to the lit digit shows on the next cycle
        restart_run(MODE_HOLD, 1'b0);
        advance_to(3);
        wr_en = 1'b1; wr_frame = 2'd0; wr_digit = 2'd0; wr_data = 8'h00;
        exp_q.push_back(pack_out(8'h07, 8'h00, 4'h0, 1'b0));
        tick();
        cur_t++;
        wr_en = 1'b0;
        sb_check("write_active_digit", main_out());
        exp_q.push_back(pack_out(8'h07, 8'h00, 4'h0, 1'b0));
        advance_to(5);
        sb_check("write_held", main_out());

        // Asynchronous reset mid-frame, then the buffer reads blank
        restart_run(MODE_ONESHOT, 1'b0);
        advance_to(140);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(pack_out(8'h0F, 8'hFF, 4'h0, 1'b0));
        sb_check("async_reset", main_out());
        tick();
        rst_n = 1'b1;
        restart_run(MODE_HOLD, 1'b0);
        for (int t = 2; t <= 17; t++) begin
            exp_q.push_back(pack_out({4'h0, ~(4'b1000 >> ((t - 2) / 4 % 4))}, 8'hFF, 4'h0, 1'b0));
            advance_to(t);
            sb_check($sformatf("post_reset_t%0d", t), main_out());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_frame_sequencer.md
Name: seg7_frame_sequencer

Overview:
- Parametrised 7-segment display sequencer: a frame buffer of FRAMES images, each holding DIGITS segment bytes.
- Time-multiplexes the digits of the current frame onto a shared seg bus, one anode at a time.
- Advances through frames on a programmable dwell time. Modes: hold, loop, ping-pong, one-shot. Optional blink.
- Sits between the top-level pattern/control logic and the board's an/seg pins; replaces per-subtask hard-coded stage sequencers.

Parameters:
- DIGITS, 4, number of display digits (anodes); 1..8.
- FRAMES, 8, frame buffer depth; 1..16.
- REFRESH_CYCLES, 100000, clock cycles each digit stays lit.
- DWELL_SCANS, 200, full digit scans per frame before advancing.
- BLINK_SCANS, 50, full scans per blink half-period.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run; 0 = freeze all counters and blank display.
- mode  in  2  0 hold, 1 loop, 2 ping-pong, 3 one-shot.
- restart  in  1  single-cycle pulse: frame 0, counters 0, direction up, done cleared.
- blink  in  1  1 = gate anodes with the blink phase.
- wr_en  in  1  frame buffer write strobe.
- wr_frame  in  clog2(FRAMES) max 1  target frame.
- wr_digit  in  clog2(DIGITS) max 1  target digit (0 = leftmost).
- wr_data  in  8  segment byte, active low {dp,g..a}.
- an  out  DIGITS  anodes, active low; an[DIGITS-1] = digit 0.
- seg  out  8  segments, active low.
- frame_idx  out  clog2(FRAMES) max 1  frame currently displayed.
- done  out  1  one-shot completed, sticky.

Behaviour:
- Reset values: an all ones, seg 8'hFF, frame_idx 0, done 0, every frame-buffer byte 8'hFF, direction up, blink phase on, all counters 0.
- Refresh counter counts 0..REFRESH_CYCLES-1. At wrap, digit index increments and wraps DIGITS-1 to 0.
- A wrap from digit DIGITS-1 to 0 is one scan.
- Dwell counter counts scans 0..DWELL_SCANS-1. At its wrap the frame advances per mode.
- Frame advance by mode:
  - hold: frame_idx unchanged.
  - loop: +1, FRAMES-1 wraps to 0.
  - ping-pong: +1 while up, reverse at FRAMES-1. -1 while down, reverse at 0. No repeated end frame: sequence is 0,1,..,F-1,F-2,..,0,1. FRAMES=1 stays at 0.
  - one-shot: +1 until FRAMES-1. At the advance event while on FRAMES-1, set done and stop. Stays done until restart or reset.
- Outputs are registered, 1-cycle latency from the digit index/frame change to an/seg. Active digit d drives an bit (DIGITS-1-d) low and seg = buf[frame_idx][d].
- Blink phase toggles every BLINK_SCANS scans. blink=1 with phase off: an all ones, seg 8'hFF. Counters keep running.
- enable=0: an all ones, seg 8'hFF on the next cycle. Counters and frame_idx hold. Resume continues from the held state.
- Writes are synchronous. A write to the displayed frame/digit is visible on seg the cycle after the write, if that digit is active.
- Out-of-range wr_frame/wr_digit writes are ignored.
- restart outranks the frame advance in the same cycle.
- A mode change takes effect at the next advance event. Entering ping-pong forces direction up.
- done is cleared on any mode change away from one-shot.
- Reset mid-scan: all state returns to reset values immediately (asynchronous). Frame buffer contents are lost.

Decomposition:
- Package seg7_pkg: mode encoding constants (MODE_HOLD/LOOP/PINGPONG/ONESHOT), SEG_BLANK = 8'hFF, and the 8-bit segment byte typedef.
- One sub-module, seg7_scan_timer: refresh, dwell and blink counters. Emits digit_idx, scan_tick, dwell_tick, blink_on; gated by enable and cleared by restart.
- Frame buffer, frame/direction FSM and output registers stay in the top.

Test Plan (DIGITS=4, FRAMES=4, REFRESH_CYCLES=4, DWELL_SCANS=2, BLINK_SCANS=3):
- Reset then write buf[0] = {C1,A3,87,8B}, mode=hold, enable=1 -> an steps 0111, 1011, 1101, 1110 every 4 cycles with seg C1, A3, 87, 8B. frame_idx stays 0 indefinitely.
- mode=loop, all frames loaded -> frame_idx 0,1,2,3,0 advancing every 32 cycles (2 scans × 16).
- mode=ping-pong -> frame_idx 0,1,2,3,2,1,0,1 at 32-cycle spacing. FRAMES=1 rerun: frame_idx remains 0.
- mode=one-shot -> frame_idx reaches 3. done rises at the advance event after frame 3 and frame_idx stays 3. restart pulse -> frame_idx 0, done 0 next cycle. restart coincident with an advance -> frame_idx 0.
- blink=1 -> an all ones for 3 scans (48 cycles), normal for 48 cycles, repeating. enable=0 mid-scan -> blank next cycle, frame_idx frozen. Re-enable -> resumes same digit and count.
- Write buf[cur][active digit] = 8'h00 -> seg 8'h00 one cycle later. Write with wr_digit=5 -> no buffer change. Assert rst_n low mid-frame -> an/seg/frame_idx/done at reset values without waiting for a clock edge.
